// File: rtl/matrix_wb_pkg.sv
// Shared types and constants for the matrix writeback scheduler.
package matrix_wb_pkg;

    localparam int MX_ROWS   = 4;
    localparam int MX_IDX_W  = 2;
    localparam int MX_DATA_W = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } wb_state_e;

    typedef enum logic [1:0] {
        SRC_MEM  = 2'd0,
        SRC_REG  = 2'd1,
        SRC_LINE = 2'd2
    } wb_src_e;

    // Load data beats register data, which beats line data.
    function automatic wb_src_e src_sel(input logic mem2matrix, input logic reg2matrix);
        if (mem2matrix) return SRC_MEM;
        if (reg2matrix) return SRC_REG;
        return SRC_LINE;
    endfunction

endpackage

// File: rtl/matrix_wb_sched.sv
// Writeback scheduler: one matrix row write per cycle, MOPA results serialized over 4 writes.
// Optional perf counters (stall cycles, accepted MOPAs) enabled by MATRIX_WB_PERF_EN.
module matrix_wb_sched
    import matrix_wb_pkg::*;
#(
    parameter int DATA_W = MX_DATA_W,
    parameter int ROWS   = MX_ROWS,
    parameter int IDX_W  = MX_IDX_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wb_matrix_write,
    input  logic                   wb_matrix_write_mopa,
    input  logic                   wb_mem2matrix,
    input  logic                   wb_mem_reg2matrix,
    input  logic [IDX_W-1:0]       wb_matrix_index,
    input  logic [DATA_W-1:0]      wb_mem_data,
    input  logic [DATA_W-1:0]      wb_regs_data1,
    input  logic [DATA_W-1:0]      wb_matrix_line_data,
    input  logic [ROWS*DATA_W-1:0] wb_matrix_mul_o,
    output logic                   mx_we,
    output logic [IDX_W-1:0]       mx_row,
    output logic [DATA_W-1:0]      mx_wdata,
    output logic                   wb_stall,
    output logic                   busy
`ifdef MATRIX_WB_PERF_EN
    ,
    output logic [31:0]            perf_stall_cnt,
    output logic [31:0]            perf_mopa_cnt
`endif
);

    localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(ROWS - 1);

    wb_state_e                     state_q, state_d;
    logic [IDX_W-1:0]              cnt_q, cnt_d;
    logic [ROWS-1:0][DATA_W-1:0]   row_buf_q, row_buf_d;
    logic                          mx_we_q, mx_we_d;
    logic [IDX_W-1:0]              mx_row_q, mx_row_d;
    logic [DATA_W-1:0]             mx_wdata_q, mx_wdata_d;
    logic                          mopa_accept;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        row_buf_d   = row_buf_q;
        mx_we_d     = 1'b0;
        mx_row_d    = mx_row_q;
        mx_wdata_d  = mx_wdata_q;
        mopa_accept = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (wb_matrix_write_mopa) begin
                    mopa_accept = 1'b1;
                    for (int i = 0; i < ROWS; i++)
                        row_buf_d[i] = wb_matrix_mul_o[i*DATA_W +: DATA_W];
                    mx_we_d    = 1'b1;
                    mx_row_d   = '0;
                    mx_wdata_d = wb_matrix_mul_o[DATA_W-1:0];
                    cnt_d      = IDX_W'(1);
                    state_d    = BURST;
                end else if (wb_matrix_write) begin
                    mx_we_d  = 1'b1;
                    mx_row_d = wb_matrix_index;
                    unique case (src_sel(wb_mem2matrix, wb_mem_reg2matrix))
                        SRC_MEM:  mx_wdata_d = wb_mem_data;
                        SRC_REG:  mx_wdata_d = wb_regs_data1;
                        default:  mx_wdata_d = wb_matrix_line_data;
                    endcase
                end
            end
            BURST: begin
                // WB still holds the MOPA here, so its inputs are ignored.
                mx_we_d    = 1'b1;
                mx_row_d   = cnt_q;
                mx_wdata_d = row_buf_q[cnt_q];
                if (cnt_q == LAST_ROW) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            row_buf_q  <= '0;
            mx_we_q    <= 1'b0;
            mx_row_q   <= '0;
            mx_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            row_buf_q  <= row_buf_d;
            mx_we_q    <= mx_we_d;
            mx_row_q   <= mx_row_d;
            mx_wdata_q <= mx_wdata_d;
        end
    end

    // Release the front end during the last-row cycle so the MOPA retires with row 3.
    assign wb_stall = (state_q == BURST) && (cnt_q != LAST_ROW);
    assign busy     = (state_q == BURST);
    assign mx_we    = mx_we_q;
    assign mx_row   = mx_row_q;
    assign mx_wdata = mx_wdata_q;

`ifdef MATRIX_WB_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_mopa_q, perf_mopa_d;

    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_mopa_d  = perf_mopa_q;
        if (wb_stall && (perf_stall_q != 32'hFFFF_FFFF))
            perf_stall_d = perf_stall_q + 32'd1;
        if (mopa_accept && (perf_mopa_q != 32'hFFFF_FFFF))
            perf_mopa_d = perf_mopa_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_q <= '0;
            perf_mopa_q  <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_mopa_q  <= perf_mopa_d;
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_mopa_cnt  = perf_mopa_q;
`else
    logic unused_mopa_accept;
    assign unused_mopa_accept = mopa_accept;
`endif

endmodule

// File: tb/tb_matrix_wb_sched.sv
// Directed self-checking bench for matrix_wb_sched.
module tb_matrix_wb_sched;
    import matrix_wb_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               wb_matrix_write, wb_matrix_write_mopa;
    logic               wb_mem2matrix, wb_mem_reg2matrix;
    logic [1:0]         wb_matrix_index;
    logic [31:0]        wb_mem_data, wb_regs_data1, wb_matrix_line_data;
    logic [127:0]       wb_matrix_mul_o;
    logic               mx_we, wb_stall, busy;
    logic [1:0]         mx_row;
    logic [31:0]        mx_wdata;
`ifdef MATRIX_WB_PERF_EN
    logic [31:0]        perf_stall_cnt, perf_mopa_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    matrix_wb_sched dut (
        .clk                  (clk),
        .rst                  (rst),
        .wb_matrix_write      (wb_matrix_write),
        .wb_matrix_write_mopa (wb_matrix_write_mopa),
        .wb_mem2matrix        (wb_mem2matrix),
        .wb_mem_reg2matrix    (wb_mem_reg2matrix),
        .wb_matrix_index      (wb_matrix_index),
        .wb_mem_data          (wb_mem_data),
        .wb_regs_data1        (wb_regs_data1),
        .wb_matrix_line_data  (wb_matrix_line_data),
        .wb_matrix_mul_o      (wb_matrix_mul_o),
        .mx_we                (mx_we),
        .mx_row               (mx_row),
        .mx_wdata             (mx_wdata),
        .wb_stall             (wb_stall),
        .busy                 (busy)
`ifdef MATRIX_WB_PERF_EN
        ,
        .perf_stall_cnt       (perf_stall_cnt),
        .perf_mopa_cnt        (perf_mopa_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        wb_matrix_write      = 1'b0;
        wb_matrix_write_mopa = 1'b0;
        wb_mem2matrix        = 1'b0;
        wb_mem_reg2matrix    = 1'b0;
        wb_matrix_index      = 2'd0;
        wb_mem_data          = 32'd0;
        wb_regs_data1        = 32'd0;
        wb_matrix_line_data  = 32'd0;
        wb_matrix_mul_o      = 128'd0;
    endtask

    task automatic chk_wr(input string tag, input logic we, input logic [1:0] row,
                          input logic [31:0] data, input logic stall, input logic bsy);
        chk({tag, ".we"},    32'(mx_we),    32'(we));
        chk({tag, ".row"},   32'(mx_row),   32'(row));
        chk({tag, ".data"},  mx_wdata,      data);
        chk({tag, ".stall"}, 32'(wb_stall), 32'(stall));
        chk({tag, ".busy"},  32'(busy),     32'(bsy));
    endtask

    initial begin
        idle_in();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk_wr("reset", 1'b0, 2'd0, 32'd0, 1'b0, 1'b0);

        // Async reset mid-cycle with a pending request
        wb_matrix_write     = 1'b1;
        wb_matrix_index     = 2'd3;
        wb_matrix_line_data = 32'h55;
        tick();
        chk_wr("pre_rst", 1'b1, 2'd3, 32'h55, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1 chk_wr("async_rst", 1'b0, 2'd0, 32'd0, 1'b0, 1'b0);
        idle_in();
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst.we", 32'(mx_we), 32'd0);

        // Single load
        wb_matrix_write = 1'b1;
        wb_mem2matrix   = 1'b1;
        wb_matrix_index = 2'd2;
        wb_mem_data     = 32'hDEAD_BEEF;
        tick();
        chk_wr("load", 1'b1, 2'd2, 32'hDEAD_BEEF, 1'b0, 1'b0);
        idle_in();
        tick();
        chk_wr("hold", 1'b0, 2'd2, 32'hDEAD_BEEF, 1'b0, 1'b0);

        // Source priority
        wb_matrix_write   = 1'b1;
        wb_mem2matrix     = 1'b1;
        wb_mem_reg2matrix = 1'b1;
        wb_mem_data       = 32'd5;
        wb_regs_data1     = 32'd7;
        wb_matrix_line_data = 32'd11;
        wb_matrix_index   = 2'd0;
        tick();
        chk("prio_mem.data", mx_wdata, 32'd5);
        wb_mem2matrix = 1'b0;
        tick();
        chk("prio_reg.data", mx_wdata, 32'd7);
        wb_mem_reg2matrix = 1'b0;
        tick();
        chk("prio_line.data", mx_wdata, 32'd11);

        // MOPA together with a single write: MOPA wins; held MOPA ignored during burst
        wb_matrix_write_mopa = 1'b1;
        wb_matrix_index      = 2'd1;
        wb_matrix_line_data  = 32'd9;
        wb_matrix_mul_o      = {32'd4, 32'd3, 32'd2, 32'd1};
        tick();
        chk_wr("mopa0", 1'b1, 2'd0, 32'd1, 1'b1, 1'b1);
        tick();
        chk_wr("mopa1", 1'b1, 2'd1, 32'd2, 1'b1, 1'b1);
        tick();
        chk_wr("mopa2", 1'b1, 2'd2, 32'd3, 1'b0, 1'b1);
        tick();
        chk_wr("mopa3", 1'b1, 2'd3, 32'd4, 1'b0, 1'b0);
`ifdef MATRIX_WB_PERF_EN
        chk("perf_stall", perf_stall_cnt, 32'd2);
        chk("perf_mopa",  perf_mopa_cnt,  32'd1);
`endif
        // MOPA has left WB; next instruction is a row-1 line write
        wb_matrix_write_mopa = 1'b0;
        tick();
        chk_wr("b2b_single", 1'b1, 2'd1, 32'd9, 1'b0, 1'b0);
        idle_in();
        tick();
        chk_wr("no_replay", 1'b0, 2'd1, 32'd9, 1'b0, 1'b0);

        // Reset during burst after row 1
        wb_matrix_write_mopa = 1'b1;
        wb_matrix_mul_o      = {32'hD, 32'hC, 32'hB, 32'hA};
        tick();
        chk_wr("abort0", 1'b1, 2'd0, 32'hA, 1'b1, 1'b1);
        tick();
        chk_wr("abort1", 1'b1, 2'd1, 32'hB, 1'b1, 1'b1);
        #2 rst = 1'b1;
        #1 chk_wr("abort_rst", 1'b0, 2'd0, 32'd0, 1'b0, 1'b0);
`ifdef MATRIX_WB_PERF_EN
        chk("abort_perf_stall", perf_stall_cnt, 32'd0);
        chk("abort_perf_mopa",  perf_mopa_cnt,  32'd0);
`endif
        idle_in();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_wr("after_abort", 1'b0, 2'd0, 32'd0, 1'b0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/matrix_wb_sched.md
Name: matrix_wb_sched

Overview:
- Writeback-stage scheduler for the 4-row matrix register file, which has a single write port.
- Consumes WB-stage matrix control and data, and issues at most one row write per cycle.
- Single-line writes (load, reg-to-matrix, line) take one write.
- MOPA results (4 rows) are buffered and serialized over 4 consecutive writes, stalling the pipeline front end as needed.

Parameters:
- DATA_W, 32, width of one matrix row word
- ROWS, 4, matrix rows per MOPA result; fixed at 4 in this revision
- IDX_W, 2, row index width, equal to clog2(ROWS)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- wb_matrix_write  in  1  single-row matrix write request
- wb_matrix_write_mopa  in  1  4-row MOPA result write request
- wb_mem2matrix  in  1  row data source is wb_mem_data
- wb_mem_reg2matrix  in  1  row data source is wb_regs_data1
- wb_matrix_index  in  IDX_W  target row for single writes
- wb_mem_data  in  DATA_W  load data
- wb_regs_data1  in  DATA_W  integer register operand
- wb_matrix_line_data  in  DATA_W  line data (default source)
- wb_matrix_mul_o  in  ROWS*DATA_W  MOPA rows, flattened; row i = [i*DATA_W +: DATA_W]
- mx_we  out  1  registered write enable to matrix file
- mx_row  out  IDX_W  registered write row
- mx_wdata  out  DATA_W  registered write data
- wb_stall  out  1  hold IF..MEM/WB registers this cycle
- busy  out  1  high while a MOPA burst is in progress

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, cnt=0, row buffer cleared.
  - mx_we=0, mx_row=0, mx_wdata=0, wb_stall=0, busy=0.
  - Reset mid-burst aborts the burst; remaining rows are discarded and no further writes are issued.
- State IDLE, sampled at each rising edge:
  - wb_matrix_write_mopa=1: MOPA wins over any single-write request.
    - Next-cycle outputs mx_we=1, row 0, data mul_o row 0.
    - Rows 1..3 captured into the buffer; cnt=1; state goes to BURST.
  - Else wb_matrix_write=1: next-cycle outputs mx_we=1, mx_row=wb_matrix_index.
    - mx_wdata priority: wb_mem2matrix, then wb_mem_reg2matrix, then wb_matrix_line_data.
  - Else: mx_we=0; mx_row and mx_wdata hold their previous values.
- State BURST:
  - WB inputs are ignored, because the MOPA instruction is still held in WB.
  - Each edge: mx_we=1, mx_row=cnt, mx_wdata=buffer[cnt], cnt increments.
  - On the edge where cnt=3: issue row 3, set cnt=0, state goes to IDLE.
- wb_stall is combinational: (state==BURST) && (cnt!=3).
  - Result: high for exactly 2 cycles per MOPA.
  - During the cnt=3 cycle the pipeline advances; the MOPA leaves WB on the same edge as the row 3 write.
  - The next instruction is sampled on the following edge.
- busy = (state==BURST).
- Latency: write appears one cycle after sampling; MOPA occupies the write port for 4 consecutive cycles.
- Back-to-back MOPAs: the second is sampled in the IDLE cycle after the first burst; no write-port bubble.
- Widths: no arithmetic beyond cnt; cnt is IDX_W wide and does not wrap past ROWS-1.

Optional Feature:
- Macro: MATRIX_WB_PERF_EN
- Defined:
  - Adds output perf_stall_cnt [31:0], counting cycles with wb_stall=1.
  - Adds output perf_mopa_cnt [31:0], counting accepted MOPAs.
  - Both reset to 0 on rst and saturate at 32'hFFFF_FFFF.
- Undefined: both ports and both counters are absent; behaviour is otherwise identical.

Decomposition:
- Package matrix_wb_pkg holds:
  - state enum {IDLE, BURST}
  - MX_ROWS=4, MX_IDX_W=2, MX_DATA_W=32
  - the data-source select encoding
- No sub-module is required. The row buffer plus counter may be split out as matrix_row_serializer if the file exceeds ~250 lines.

Test Plan:
- Reset: assert rst mid-cycle with valid inputs present -> all outputs 0 immediately, no mx_we after release until a new request.
- Single load: wb_matrix_write=1, wb_mem2matrix=1, index=2, mem_data=32'hDEAD_BEEF -> next cycle mx_we=1, mx_row=2, mx_wdata=32'hDEAD_BEEF; wb_stall stays 0.
- Priority: write with mem2matrix=1 and reg2matrix=1, mem_data=5, regs_data1=7 -> mx_wdata=5. Then write+mopa together -> burst taken.
- MOPA: mul_o rows {1,2,3,4} -> mx_we=1 for 4 cycles with rows 0..3 and data 1..4; wb_stall=1 for exactly 2 cycles; busy=1 for 3 cycles.
- Back-to-back: MOPA then single write (index 1, line_data=9) -> 4 burst writes, then a row-1 write of 9 on the very next cycle; the held MOPA is never replayed.
- Reset during burst after row 1 is written -> rows 2..3 never written, state IDLE; with MATRIX_WB_PERF_EN, counters read 0.
